// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    localparam int OUT_DEPTH = 2;
    localparam int OCC_W     = $clog2(OUT_DEPTH + 1);

    typedef logic [OCC_W-1:0] occ_t;

    // A new read may be issued only if the words already owned by the adapter
    // (buffered plus in flight, less the one leaving this cycle) leave room for it.
    function automatic logic issue_ok(input occ_t occ, input logic inflight, input logic pop);
        logic [OCC_W:0] pending;
        pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
        return pending <= (OCC_W + 1)'(OUT_DEPTH - 1);
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer: head drives the stream, tail absorbs one extra word.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data
);

    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    // Next-state of the buffer for every push/pop combination; flush empties it.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == '0) head_d = push_data;
                else             tail_d = push_data;
                occ_d = occ_q + 1'b1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 1'b1;
            end
            2'b11: begin
                // Head leaves; the next word in line takes its place, count is unchanged.
                if (occ_q == occ_t'(OUT_DEPTH)) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
        if (flush) occ_d = '0;
    end

    // Occupancy and head register; head resets so the stream output starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            head_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    // Tail holds data only; it is never visible while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    assign occ     = occ_q;
    assign m_valid = (occ_q != '0);
    assign m_data  = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns the one-cycle-latency FIFO read port into a valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    occ_t             occ;
    logic             pop;
    logic             push;

    assign pop = m_valid & m_ready;

    // Read issue, in-flight tracking and delivery counting.
    always_comb begin
        rinc       = !rempty && !flush && !rst && issue_ok(occ, inflight_q, pop);
        inflight_d = rinc;
        // A word landing on rdata during a flush is dropped rather than buffered.
        push       = inflight_q && !flush;
        xfer_cnt_d = xfer_cnt_q + CNT_W'(pop);
    end

    // Control registers; flush clears inflight through rinc, only reset clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    stream_buf2 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_data(rdata),
        .pop      (pop),
        .occ      (occ),
        .m_valid  (m_valid),
        .m_data   (m_data)
    );

    assign xfer_cnt = xfer_cnt_q;

endmodule
